uart_tx_cfg: RTL and testbench

Parametrised successor to the fixed 8N1 UART transmitter. It supports a parameter-set data width, runtime parity (none/odd/even) and runtime 1 or 2 stop bits. It reads from a first-word-fall-through FIFO and sends back-to-back frames with no idle gap. It sits between the TX FIFO and the IR/serial line driver.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_tx_cfg_if.sv | 24 ++
 rtl/uart_baud_cnt.sv | 25 ++
 rtl/uart_tx_cfg.sv | 129 ++++++++++++
 tb/tb_uart_tx_cfg.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings and FSM state encoding.
// Used by both the transmitter and the matching receiver.
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    typedef enum logic [2:0] {
        StIdle   = ST_IDLE,
        StStart  = ST_START,
        StData   = ST_DATA,
        StParity = ST_PARITY,
        StStop   = ST_STOP
    } tx_state_e;

endpackage

// File: rtl/uart_tx_cfg_if.sv
// FIFO-side and line-side signals of the configurable UART transmitter.
// master drives the FIFO/config side, slave is the transmitter.
interface uart_tx_cfg_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic                 i_Tx_DV;
    logic [DATA_BITS-1:0] i_Tx_Byte;
    logic [1:0]           i_Parity;
    logic                 i_Two_Stop;
    logic                 o_fifo_rd;
    logic                 o_Tx_Active;
    logic                 o_Tx_Serial;
    logic                 o_Tx_Done;

    modport master (
        output i_Tx_DV, i_Tx_Byte, i_Parity, i_Two_Stop,
        input  o_fifo_rd, o_Tx_Active, o_Tx_Serial, o_Tx_Done
    );

    modport slave (
        input  i_Tx_DV, i_Tx_Byte, i_Parity, i_Two_Stop,
        output o_fifo_rd, o_Tx_Active, o_Tx_Serial, o_Tx_Done
    );
endinterface

// File: rtl/uart_baud_cnt.sv
// Baud-rate divider: counts 0..CLKS_PER_BIT-1 while enabled, flags the last clock of a bit.
// Shared by the TX and RX sides.
module uart_baud_cnt #(
    parameter int unsigned CLKS_PER_BIT = 104
) (
    input  logic i_Clock,
    input  logic i_Rst_n,
    input  logic i_En,
    output logic o_Bit_End
);
    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);

    logic [CntW-1:0] cnt_q;

    assign o_Bit_End = i_En && (cnt_q == CntLast);

    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) begin
            cnt_q <= '0;
        end else if (i_En) begin
            cnt_q <= o_Bit_End ? '0 : cnt_q + 1'b1;
        end
    end
endmodule

// File: rtl/uart_tx_cfg.sv
// UART transmitter with parameter data width, runtime parity and stop-bit count,
// fed from a first-word-fall-through FIFO; frames go out back to back.
module uart_tx_cfg #(
    parameter int unsigned CLKS_PER_BIT = 104,
    parameter int unsigned DATA_BITS    = 8
) (
    input  logic          i_Clock,
    input  logic          i_Rst_n,
    uart_tx_cfg_if.slave  tx
);
    import uart_pkg::*;

    localparam int unsigned IdxW = $clog2(DATA_BITS);

    tx_state_e            state_q;
    logic [DATA_BITS-1:0] data_q;
    logic [1:0]           par_q;
    logic                 two_stop_q;
    logic [IdxW-1:0]      idx_q;
    logic                 serial_q;
    logic                 active_q;
    logic                 done_q;
    logic                 rd_q;

    logic            bit_end;
    logic            par_en;
    logic            par_bit;
    logic            last_data;
    logic            last_stop;
    logic            frame_end;
    logic            take;
    logic [IdxW-1:0] idx_nx;

    uart_baud_cnt #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_cnt (
        .i_Clock   (i_Clock),
        .i_Rst_n   (i_Rst_n),
        .i_En      (state_q != StIdle),
        .o_Bit_End (bit_end)
    );

    assign par_en    = (par_q == PAR_ODD) || (par_q == PAR_EVEN);
    assign par_bit   = (^data_q) ^ (par_q == PAR_ODD);
    assign last_data = (idx_q == IdxW'(DATA_BITS - 1));
    // Stop bits reuse the bit index: index 1 is the second stop bit.
    assign last_stop = (idx_q == {{(IdxW-1){1'b0}}, two_stop_q});
    assign frame_end = (state_q == StStop) && bit_end && last_stop;
    assign take      = tx.i_Tx_DV && ((state_q == StIdle) || frame_end);
    assign idx_nx    = idx_q + 1'b1;

    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) begin
            state_q    <= StIdle;
            data_q     <= '0;
            par_q      <= PAR_NONE;
            two_stop_q <= 1'b0;
            idx_q      <= '0;
            serial_q   <= 1'b1;
            active_q   <= 1'b0;
            done_q     <= 1'b0;
            rd_q       <= 1'b0;
        end else begin
            rd_q   <= 1'b0;
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: serial_q <= 1'b1;
                StStart: begin
                    if (bit_end) begin
                        state_q  <= StData;
                        idx_q    <= '0;
                        serial_q <= data_q[0];
                    end
                end
                StData: begin
                    if (bit_end) begin
                        if (last_data) begin
                            idx_q <= '0;
                            if (par_en) begin
                                state_q  <= StParity;
                                serial_q <= par_bit;
                            end else begin
                                state_q  <= StStop;
                                serial_q <= 1'b1;
                            end
                        end else begin
                            idx_q    <= idx_nx;
                            serial_q <= data_q[idx_nx];
                        end
                    end
                end
                StParity: begin
                    if (bit_end) begin
                        state_q  <= StStop;
                        serial_q <= 1'b1;
                    end
                end
                StStop: begin
                    if (bit_end) begin
                        if (last_stop) begin
                            done_q   <= 1'b1;
                            state_q  <= StIdle;
                            active_q <= 1'b0;
                        end else begin
                            idx_q <= idx_nx;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
            // A new frame start overrides the idle/end-of-frame updates above.
            if (take) begin
                data_q     <= tx.i_Tx_Byte;
                par_q      <= tx.i_Parity;
                two_stop_q <= tx.i_Two_Stop;
                rd_q       <= 1'b1;
                active_q   <= 1'b1;
                serial_q   <= 1'b0;
                idx_q      <= '0;
                state_q    <= StStart;
            end
        end
    end

    assign tx.o_Tx_Serial = serial_q;
    assign tx.o_Tx_Active = active_q;
    assign tx.o_Tx_Done   = done_q;
    assign tx.o_fifo_rd   = rd_q;
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: frame-level model checked every cycle, plus literal frame patterns.
module tb_uart_tx_cfg;
    localparam int CPB = 4;

    typedef struct {
        logic        busy;
        int          cyc;
        int          nb;
        logic [15:0] bits;
        logic        ser;
        logic        act;
        logic        done;
        logic        rd;
    } mdl_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    uart_tx_cfg_if #(.DATA_BITS(8)) if8 ();
    uart_tx_cfg_if #(.DATA_BITS(5)) if5 ();

    uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut8 (
        .i_Clock (clk),
        .i_Rst_n (rst_n),
        .tx      (if8)
    );

    uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(5)) dut5 (
        .i_Clock (clk),
        .i_Rst_n (rst_n),
        .tx      (if5)
    );

    int total = 0;
    int bad   = 0;
    logic chk_en = 1'b0;

    mdl_t m8 = '{busy: 1'b0, cyc: 0, nb: 0, bits: '0, ser: 1'b1, act: 1'b0, done: 1'b0, rd: 1'b0};
    mdl_t m5 = '{busy: 1'b0, cyc: 0, nb: 0, bits: '0, ser: 1'b1, act: 1'b0, done: 1'b0, rd: 1'b0};

    logic [7:0] fifo8[$];
    logic [4:0] fifo5[$];
    logic       cap8[$];
    logic       cap5[$];
    int rd_cnt8, done_cnt8, fall_cnt8, done_at8;
    int rd_cnt5, done_cnt5;
    logic done_act8, prev_act8;

    // Frame as a bit list, each bit lasting CPB clocks; frames chain when data is waiting.
    function automatic mdl_t mdl_step(input mdl_t m, input logic rst, input logic dv,
                                      input logic [8:0] data, input int nd,
                                      input logic [1:0] par, input logic two);
        mdl_t r = m;
        int ones;
        r.done = 1'b0;
        r.rd   = 1'b0;
        if (!rst) begin
            r.busy = 1'b0;
            r.ser  = 1'b1;
            r.act  = 1'b0;
            return r;
        end
        if (r.busy) begin
            r.cyc++;
            if (r.cyc == r.nb * CPB) begin
                r.busy = 1'b0;
                r.done = 1'b1;
            end
        end
        if (!r.busy && dv) begin
            ones = 0;
            r.bits = '1;
            r.bits[0] = 1'b0;
            for (int i = 0; i < nd; i++) begin
                r.bits[1+i] = data[i];
                ones += int'(data[i]);
            end
            r.nb = 1 + nd;
            if (par == 2'b01 || par == 2'b10) begin
                r.bits[r.nb] = (par == 2'b10) ? ones[0] : ~ones[0];
                r.nb++;
            end
            r.nb += two ? 2 : 1;
            r.busy = 1'b1;
            r.cyc  = 0;
            r.rd   = 1'b1;
        end
        r.ser = r.busy ? r.bits[r.cyc / CPB] : 1'b1;
        r.act = r.busy;
        return r;
    endfunction

    always @(posedge clk) begin
        m8 = mdl_step(m8, rst_n, if8.i_Tx_DV, {1'b0, if8.i_Tx_Byte}, 8, if8.i_Parity,
                      if8.i_Two_Stop);
        m5 = mdl_step(m5, rst_n, if5.i_Tx_DV, {4'b0, if5.i_Tx_Byte}, 5, if5.i_Parity,
                      if5.i_Two_Stop);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic int pat_err(input logic q[$], input logic [31:0] pat, input int n);
        int e = 0;
        for (int k = 0; k < q.size(); k++) begin
            int b = k / CPB;
            if (b >= n || q[k] !== pat[n-1-b]) e++;
        end
        return e;
    endfunction

    // One clock: compare against the model, capture, service the FIFOs, drive FIFO heads.
    task automatic tick();
        @(negedge clk);
        if (chk_en) begin
            check("ser8", 32'(if8.o_Tx_Serial), 32'(m8.ser));
            check("act8", 32'(if8.o_Tx_Active), 32'(m8.act));
            check("done8", 32'(if8.o_Tx_Done), 32'(m8.done));
            check("rd8", 32'(if8.o_fifo_rd), 32'(m8.rd));
            check("ser5", 32'(if5.o_Tx_Serial), 32'(m5.ser));
            check("act5", 32'(if5.o_Tx_Active), 32'(m5.act));
            check("done5", 32'(if5.o_Tx_Done), 32'(m5.done));
            check("rd5", 32'(if5.o_fifo_rd), 32'(m5.rd));
        end
        if (if8.o_Tx_Active) cap8.push_back(if8.o_Tx_Serial);
        if (if8.o_Tx_Done) begin
            done_cnt8++;
            done_at8  = cap8.size();
            done_act8 = if8.o_Tx_Active;
        end
        if (prev_act8 && !if8.o_Tx_Active) fall_cnt8++;
        prev_act8 = if8.o_Tx_Active;
        if (if8.o_fifo_rd) begin
            rd_cnt8++;
            if (fifo8.size() != 0) void'(fifo8.pop_front());
        end
        if (if5.o_Tx_Active) cap5.push_back(if5.o_Tx_Serial);
        if (if5.o_Tx_Done) done_cnt5++;
        if (if5.o_fifo_rd) begin
            rd_cnt5++;
            if (fifo5.size() != 0) void'(fifo5.pop_front());
        end
        if8.i_Tx_DV   = (fifo8.size() != 0);
        if8.i_Tx_Byte = (fifo8.size() != 0) ? fifo8[0] : 8'h00;
        if5.i_Tx_DV   = (fifo5.size() != 0);
        if5.i_Tx_Byte = (fifo5.size() != 0) ? fifo5[0] : 5'h00;
    endtask

    task automatic clear_stats();
        cap8.delete();
        cap5.delete();
        rd_cnt8 = 0; done_cnt8 = 0; fall_cnt8 = 0; done_at8 = -1; done_act8 = 1'bx;
        rd_cnt5 = 0; done_cnt5 = 0;
    endtask

    task automatic wait_done8(input int n, input int bound);
        for (int i = 0; i < bound && done_cnt8 < n; i++) tick();
        check("wait_done8", 32'(done_cnt8), 32'(n));
        repeat (3) tick();
    endtask

    initial begin
        rst_n = 1'b0;
        prev_act8 = 1'b0;
        if8.i_Tx_DV = 1'b0; if8.i_Tx_Byte = '0; if8.i_Parity = 2'b00; if8.i_Two_Stop = 1'b0;
        if5.i_Tx_DV = 1'b0; if5.i_Tx_Byte = '0; if5.i_Parity = 2'b00; if5.i_Two_Stop = 1'b0;
        clear_stats();
        repeat (3) tick();
        check("rst_ser", 32'(if8.o_Tx_Serial), 32'd1);
        check("rst_act", 32'(if8.o_Tx_Active), 32'd0);
        check("rst_done", 32'(if8.o_Tx_Done), 32'd0);
        check("rst_rd", 32'(if8.o_fifo_rd), 32'd0);
        chk_en = 1'b1;
        rst_n = 1'b1;
        repeat (2) tick();

        // 8N1, 0xA5
        clear_stats();
        fifo8.push_back(8'hA5);
        wait_done8(1, 200);
        check("a5_len", 32'(cap8.size()), 32'd40);
        check("a5_pat", 32'(pat_err(cap8, 32'b0101001011, 10)), 32'd0);
        check("a5_rd", 32'(rd_cnt8), 32'd1);
        check("a5_done", 32'(done_cnt8), 32'd1);
        check("a5_done_at", 32'(done_at8), 32'd40);
        check("a5_act_fall", 32'(done_act8), 32'd0);

        // Even then odd parity on 0x07
        clear_stats();
        if8.i_Parity = 2'b10;
        fifo8.push_back(8'h07);
        wait_done8(1, 200);
        check("even_len", 32'(cap8.size()), 32'd44);
        check("even_pat", 32'(pat_err(cap8, 32'b01110000011, 11)), 32'd0);
        clear_stats();
        if8.i_Parity = 2'b01;
        fifo8.push_back(8'h07);
        wait_done8(1, 200);
        check("odd_len", 32'(cap8.size()), 32'd44);
        check("odd_pat", 32'(pat_err(cap8, 32'b01110000001, 11)), 32'd0);

        // Two stop bits on 0x00
        clear_stats();
        if8.i_Parity = 2'b00;
        if8.i_Two_Stop = 1'b1;
        fifo8.push_back(8'h00);
        wait_done8(1, 200);
        check("2stop_len", 32'(cap8.size()), 32'd44);
        check("2stop_pat", 32'(pat_err(cap8, 32'b00000000011, 11)), 32'd0);

        // Three back-to-back frames
        clear_stats();
        if8.i_Two_Stop = 1'b0;
        fifo8.push_back(8'h11);
        fifo8.push_back(8'h22);
        fifo8.push_back(8'h33);
        wait_done8(3, 400);
        check("b2b_len", 32'(cap8.size()), 32'd120);
        check("b2b_pat",
              32'(pat_err(cap8, 32'b0100010001_0010001001_0110011001, 30)), 32'd0);
        check("b2b_rd", 32'(rd_cnt8), 32'd3);
        check("b2b_done", 32'(done_cnt8), 32'd3);
        check("b2b_falls", 32'(fall_cnt8), 32'd1);

        // 5-bit data, odd parity, 0x1F
        clear_stats();
        if5.i_Parity = 2'b01;
        fifo5.push_back(5'h1F);
        for (int i = 0; i < 200 && done_cnt5 < 1; i++) tick();
        check("d5_wait", 32'(done_cnt5), 32'd1);
        repeat (3) tick();
        check("d5_len", 32'(cap5.size()), 32'd32);
        check("d5_pat", 32'(pat_err(cap5, 32'b01111101, 8)), 32'd0);
        check("d5_rd", 32'(rd_cnt5), 32'd1);

        // Reset asserted at clock 17 of a frame
        clear_stats();
        fifo8.push_back(8'hA5);
        for (int i = 0; i < 20 && !if8.o_Tx_Active; i++) tick();
        check("rstmid_start", 32'(if8.o_Tx_Active), 32'd1);
        repeat (16) tick();
        rst_n = 1'b0;
        tick();
        check("rstmid_ser", 32'(if8.o_Tx_Serial), 32'd1);
        check("rstmid_act", 32'(if8.o_Tx_Active), 32'd0);
        rst_n = 1'b1;
        repeat (10) tick();
        check("rstmid_done", 32'(done_cnt8), 32'd0);
        check("rstmid_idle", 32'(if8.o_Tx_Serial), 32'd1);
        check("rstmid_rd", 32'(rd_cnt8), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
